// File: rtl/processing_element_ws_db_pkg.sv
// Shared definitions for the weight-stationary double-buffered PE and its
// array controller: control encodings and mode-decode helpers.
package processing_element_ws_db_pkg;

  typedef logic [1:0] pe_ctrl_t;

  localparam pe_ctrl_t PE_IDLE         = 2'b00;
  localparam pe_ctrl_t PE_SWAP         = 2'b01;
  localparam pe_ctrl_t PE_COMPUTE      = 2'b10;
  localparam pe_ctrl_t PE_COMPUTE_SWAP = 2'b11;

  // Mode performs a multiply-accumulate this cycle.
  function automatic logic pe_is_compute(input pe_ctrl_t c);
    return (c == PE_COMPUTE) || (c == PE_COMPUTE_SWAP);
  endfunction

  // Mode promotes the shadow weight to active at this edge.
  function automatic logic pe_is_swap(input pe_ctrl_t c);
    return (c == PE_SWAP) || (c == PE_COMPUTE_SWAP);
  endfunction

  // Mode clears the sticky overflow flag.
  function automatic logic pe_is_idle(input pe_ctrl_t c);
    return c == PE_IDLE;
  endfunction

endpackage

// File: rtl/processing_element_ws_db_pe_mac_sat.sv
// pe_mac_sat: combinational multiply, extend, add, overflow detect and clamp.
//   w, a   : weight and activation operands (WORD_WIDTH)
//   d      : incoming partial sum (ACC_WIDTH)
//   sum_c  : d + ext(w*a), clamped or wrapped on overflow
//   ovf_c  : overflow occurred on this accumulate
// ACC_WIDTH must be >= 2*WORD_WIDTH.
module pe_mac_sat #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter bit          SIGNED     = 1'b1,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic [WORD_WIDTH-1:0] w,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0]  d,
  output logic [ACC_WIDTH-1:0]  sum_c,
  output logic                  ovf_c
);

  localparam int unsigned PROD_W = 2 * WORD_WIDTH;
  localparam int unsigned MSB    = ACC_WIDTH - 1;

  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};

  logic [PROD_W-1:0]    prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   raw;

  // Arithmetic datapath; the extra raw bit is the unsigned carry out.
  always_comb begin
    prod     = '0;
    prod_ext = '0;
    raw      = '0;
    ovf_c    = 1'b0;
    sum_c    = '0;

    if (SIGNED) begin
      prod     = PROD_W'($signed(w)) * PROD_W'($signed(a));
      prod_ext = ACC_WIDTH'($signed(prod));
    end else begin
      prod     = PROD_W'(w) * PROD_W'(a);
      prod_ext = ACC_WIDTH'(prod);
    end

    raw = {1'b0, d} + {1'b0, prod_ext};

    if (SIGNED) begin
      // Same-sign addends whose result flips sign.
      ovf_c = (d[MSB] == prod_ext[MSB]) && (raw[MSB] != d[MSB]);
    end else begin
      ovf_c = raw[ACC_WIDTH];
    end

    if (ovf_c && SATURATE) begin
      if (SIGNED) begin
        sum_c = d[MSB] ? SMIN : SMAX;
      end else begin
        sum_c = UMAX;
      end
    end else begin
      sum_c = raw[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/processing_element_ws_db.sv
// processing_element_ws_db: weight-stationary systolic PE with a shadow weight
// register loaded through a vertical shift chain and swapped in on command.
//   clk, reset            : clock, async active-high reset
//   control / control_out : 00 IDLE, 01 SWAP, 10 COMPUTE, 11 COMPUTE_SWAP
//   a_in / a_out          : activation, flows right
//   d_in / d_out          : partial sum, flows down
//   w_in / w_out          : weight shift chain, w_out is the shadow weight
//   w_load_in / w_load_out: shift-chain enable, flows down
//   ovf_flag              : sticky overflow, cleared by reset or IDLE
module processing_element_ws_db
  import processing_element_ws_db_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter bit          SIGNED     = 1'b1,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            control,
  input  logic [WORD_WIDTH-1:0] a_in,
  input  logic [ACC_WIDTH-1:0]  d_in,
  input  logic [WORD_WIDTH-1:0] w_in,
  input  logic                  w_load_in,
  output logic [1:0]            control_out,
  output logic [WORD_WIDTH-1:0] a_out,
  output logic [ACC_WIDTH-1:0]  d_out,
  output logic [WORD_WIDTH-1:0] w_out,
  output logic                  w_load_out,
  output logic                  ovf_flag
);

  logic [WORD_WIDTH-1:0] w_shadow;
  logic [WORD_WIDTH-1:0] w_active;
  logic [ACC_WIDTH-1:0]  mac_sum_c;
  logic                  mac_ovf_c;
  logic                  compute_c;
  logic                  swap_c;
  logic                  idle_c;

  assign compute_c = pe_is_compute(control);
  assign swap_c    = pe_is_swap(control);
  assign idle_c    = pe_is_idle(control);
  assign w_out     = w_shadow;

  pe_mac_sat #(
    .WORD_WIDTH (WORD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_mac (
    .w     (w_active),
    .a     (a_in),
    .d     (d_in),
    .sum_c (mac_sum_c),
    .ovf_c (mac_ovf_c)
  );

  // Weight chain and swap: a swap always takes the pre-edge shadow value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_shadow   <= '0;
      w_active   <= '0;
      w_load_out <= 1'b0;
    end else begin
      w_load_out <= w_load_in;
      if (w_load_in) begin
        w_shadow <= w_in;
      end
      if (swap_c) begin
        w_active <= w_shadow;
      end
    end
  end

  // Datapath outputs and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_out <= '0;
      a_out       <= '0;
      d_out       <= '0;
      ovf_flag    <= 1'b0;
    end else begin
      control_out <= control;
      if (compute_c) begin
        a_out <= a_in;
        d_out <= mac_sum_c;
        if (mac_ovf_c) begin
          ovf_flag <= 1'b1;
        end
      end else begin
        a_out <= '0;
        d_out <= '0;
        if (idle_c) begin
          ovf_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_processing_element_ws_db.sv
module tb_processing_element_ws_db;

  localparam int unsigned WW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned ND = 3;

  typedef struct {
    string       tag;
    int unsigned dut;
    logic [31:0] d;
    logic [7:0]  a;
    logic        ovf;
    logic [1:0]  ctl;
    logic [7:0]  w;
    logic        wl;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    control;
  logic [WW-1:0] a_in;
  logic [AW-1:0] d_in;
  logic [WW-1:0] w_in;
  logic          w_load_in;

  logic [1:0]    control_out [ND];
  logic [WW-1:0] a_out       [ND];
  logic [AW-1:0] d_out       [ND];
  logic [WW-1:0] w_out       [ND];
  logic          w_load_out  [ND];
  logic          ovf_flag    [ND];

  exp_t        sb[$];
  logic [7:0]  sh_m;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // 0: signed saturating, 1: unsigned saturating, 2: signed wrapping
  processing_element_ws_db #(.WORD_WIDTH(WW), .ACC_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b1)) u_ss (
    .clk(clk), .reset(reset), .control(control), .a_in(a_in), .d_in(d_in), .w_in(w_in),
    .w_load_in(w_load_in), .control_out(control_out[0]), .a_out(a_out[0]), .d_out(d_out[0]),
    .w_out(w_out[0]), .w_load_out(w_load_out[0]), .ovf_flag(ovf_flag[0]));

  processing_element_ws_db #(.WORD_WIDTH(WW), .ACC_WIDTH(AW), .SIGNED(1'b0), .SATURATE(1'b1)) u_us (
    .clk(clk), .reset(reset), .control(control), .a_in(a_in), .d_in(d_in), .w_in(w_in),
    .w_load_in(w_load_in), .control_out(control_out[1]), .a_out(a_out[1]), .d_out(d_out[1]),
    .w_out(w_out[1]), .w_load_out(w_load_out[1]), .ovf_flag(ovf_flag[1]));

  processing_element_ws_db #(.WORD_WIDTH(WW), .ACC_WIDTH(AW), .SIGNED(1'b1), .SATURATE(1'b0)) u_sw (
    .clk(clk), .reset(reset), .control(control), .a_in(a_in), .d_in(d_in), .w_in(w_in),
    .w_load_in(w_load_in), .control_out(control_out[2]), .a_out(a_out[2]), .d_out(d_out[2]),
    .w_out(w_out[2]), .w_load_out(w_load_out[2]), .ovf_flag(ovf_flag[2]));

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, $sformatf("d_out[%0d]", e.dut), d_out[e.dut], e.d);
      cmp(e.tag, $sformatf("a_out[%0d]", e.dut), 32'(a_out[e.dut]), 32'(e.a));
      cmp(e.tag, $sformatf("ovf[%0d]", e.dut), 32'(ovf_flag[e.dut]), 32'(e.ovf));
      cmp(e.tag, $sformatf("ctl_out[%0d]", e.dut), 32'(control_out[e.dut]), 32'(e.ctl));
      cmp(e.tag, $sformatf("w_out[%0d]", e.dut), 32'(w_out[e.dut]), 32'(e.w));
      cmp(e.tag, $sformatf("w_load_out[%0d]", e.dut), 32'(w_load_out[e.dut]), 32'(e.wl));
    end
  endtask

  task automatic push(input string tag, input int unsigned dut, input logic [31:0] d, input logic [7:0] a,
                      input logic ovf, input logic [1:0] ctl, input logic [7:0] w, input logic wl);
    exp_t e;
    e.tag = tag; e.dut = dut; e.d = d; e.a = a; e.ovf = ovf; e.ctl = ctl; e.w = w; e.wl = wl;
    sb.push_back(e);
  endtask

  // Outputs must all read zero right now (used while reset is asserted).
  task automatic check_zero(input string tag);
    for (int i = 0; i < int'(ND); i++) push(tag, i, '0, '0, 1'b0, 2'b00, '0, 1'b0);
    drain();
  endtask

  // Drive one cycle of stimulus, queue per-instance expectations, clock, compare.
  task automatic step(input string tag, input logic [1:0] ctl, input logic [7:0] a, input logic [31:0] d,
                      input logic wl, input logic [7:0] w,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                      input logic o0, input logic o1, input logic o2);
    logic [7:0] ea;
    control = ctl; a_in = a; d_in = d; w_load_in = wl; w_in = w;
    if (wl) sh_m = w;
    ea = ctl[1] ? a : 8'h00;
    push(tag, 0, e0, ea, o0, ctl, sh_m, wl);
    push(tag, 1, e1, ea, o1, ctl, sh_m, wl);
    push(tag, 2, e2, ea, o2, ctl, sh_m, wl);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    reset = 1'b1; control = 2'b00; a_in = '0; d_in = '0; w_in = '0; w_load_in = 1'b0;
    sh_m = '0;
    #12;
    check_zero("reset");
    reset = 1'b0;

    // Weight load and use
    step("load5",  2'b00, 8'd0, 32'd0,  1'b1, 8'd5, 0, 0, 0, 0, 0, 0);
    step("swap5",  2'b01, 8'd0, 32'd0,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);
    step("mac25",  2'b10, 8'd3, 32'd10, 1'b0, 8'd0, 25, 25, 25, 0, 0, 0);

    // Overlapped reload: compute with old weight, swap takes pre-edge shadow
    step("cswap",  2'b11, 8'd2, 32'd0,  1'b1, 8'd7, 10, 10, 10, 0, 0, 0);
    step("swap7",  2'b01, 8'd0, 32'd0,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);
    step("mac14",  2'b10, 8'd2, 32'd0,  1'b0, 8'd0, 14, 14, 14, 0, 0, 0);

    // Signed arithmetic, -3 * 4 + 5
    step("loadFD", 2'b00, 8'd0, 32'd0,  1'b1, 8'hFD, 0, 0, 0, 0, 0, 0);
    step("swapFD", 2'b01, 8'd0, 32'd0,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);
    step("sgn",    2'b10, 8'd4, 32'd5,  1'b0, 8'd0, 32'hFFFF_FFF9, 32'h0000_03F9, 32'hFFFF_FFF9, 0, 0, 0);

    // Positive saturation, stickiness, IDLE clear
    step("load1",  2'b00, 8'd0, 32'd0,  1'b1, 8'd1, 0, 0, 0, 0, 0, 0);
    step("swap1",  2'b01, 8'd0, 32'd0,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);
    step("satpos", 2'b10, 8'd1, 32'h7FFF_FFFF, 1'b0, 8'd0,
         32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1, 0, 1);
    step("sticky", 2'b10, 8'd0, 32'd1,  1'b0, 8'd0, 1, 1, 1, 1, 0, 1);
    step("swaphold", 2'b01, 8'd0, 32'd0, 1'b0, 8'd0, 0, 0, 0, 1, 0, 1);
    step("idleclr", 2'b00, 8'd0, 32'd0, 1'b0, 8'd0, 0, 0, 0, 0, 0, 0);

    // Unsigned saturation and signed negative saturation
    step("load2",  2'b00, 8'd0, 32'd0,  1'b1, 8'd2, 0, 0, 0, 0, 0, 0);
    step("swap2",  2'b01, 8'd0, 32'd0,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);
    step("usat",   2'b10, 8'd3, 32'hFFFF_FFFF, 1'b0, 8'd0,
         32'd5, 32'hFFFF_FFFF, 32'd5, 0, 1, 0);
    step("satneg", 2'b10, 8'h80, 32'h8000_0000, 1'b0, 8'd0,
         32'h8000_0000, 32'h8000_0100, 32'h7FFF_FF00, 1, 1, 1);

    // Asynchronous reset between edges discards weights and flags
    step("prerst", 2'b10, 8'd9, 32'd4,  1'b0, 8'd0, 22, 22, 22, 1, 1, 1);
    #2;
    reset = 1'b1;
    sh_m  = '0;
    #1;
    check_zero("asyncrst");
    #1;
    reset = 1'b0;
    step("postrst", 2'b10, 8'd9, 32'd4, 1'b0, 8'd0, 4, 4, 4, 0, 0, 0);

    // Control propagation 10, 11, 01, 00
    step("ctl10",  2'b10, 8'd1, 32'd1,  1'b0, 8'd0, 1, 1, 1, 0, 0, 0);
    step("ctl11",  2'b11, 8'd1, 32'd1,  1'b0, 8'd0, 1, 1, 1, 0, 0, 0);
    step("ctl01",  2'b01, 8'd1, 32'd1,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);
    step("ctl00",  2'b00, 8'd1, 32'd1,  1'b0, 8'd0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
